// File: rtl/fetch_pc_unit_if.sv
// Fetch-side bus bundle: imem request/response, decode handoff and jump-select redirect.
// The master modport is the fetch unit; the slave modport is the surrounding environment.
interface fetch_pc_unit_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic [31:0] pcadded;
  logic [27:0] fjump;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        misalign_err;

  modport master (
    output imem_req_valid, imem_addr, instr_valid, instr_out, pc_out, pcadded, fjump,
           misalign_err,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready, redirect_valid,
           redirect_pc
  );

  modport slave (
    input  imem_req_valid, imem_addr, instr_valid, instr_out, pc_out, pcadded, fjump,
           misalign_err,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready, redirect_valid,
           redirect_pc
  );
endinterface

// File: rtl/fetch_pc_unit.sv
// Fetch PC unit: holds the architectural PC, issues imem reads and hands the fetched
// instruction with PC+STEP and the jump target field to decode; accepts redirects back.
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  fetch_pc_unit_if.master bus
);

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_HOLD
  } state_t;

  state_t      state, state_n;
  logic [31:0] pc, pc_n;
  logic        drop, drop_n;
  logic        run;
  logic        latch;
  logic [31:0] instr_q;
  logic [31:0] pc_q;
  logic        misalign_q;
  logic [31:0] redirect_aligned;
  logic        req_fire;

  assign redirect_aligned = {bus.redirect_pc[31:2], 2'b00};

  // run holds the request off until the first edge after reset release
  assign bus.imem_req_valid = run && (state == S_REQ);
  assign req_fire           = bus.imem_req_valid && bus.imem_req_ready;
  assign bus.imem_addr      = pc;

  assign bus.instr_valid  = (state == S_HOLD);
  assign bus.instr_out    = instr_q;
  assign bus.pc_out       = pc_q;
  assign bus.pcadded      = pc_q + 32'(PC_STEP);
  assign bus.fjump        = {instr_q[25:0], 2'b00};
  assign bus.misalign_err = misalign_q;

  always_comb begin
    state_n = state;
    pc_n    = pc;
    drop_n  = drop;
    latch   = 1'b0;
    unique case (state)
      S_REQ: begin
        if (req_fire) begin
          state_n = S_WAIT;
          if (bus.redirect_valid) drop_n = 1'b1;
        end
        if (bus.redirect_valid) pc_n = redirect_aligned;
      end
      S_WAIT: begin
        // a redirect kills the outstanding response whether it lands now or later
        if (bus.imem_rsp_valid) begin
          if (drop || bus.redirect_valid) begin
            state_n = S_REQ;
            drop_n  = 1'b0;
          end else begin
            latch   = 1'b1;
            state_n = S_HOLD;
          end
        end else if (bus.redirect_valid) begin
          drop_n = 1'b1;
        end
        if (bus.redirect_valid) pc_n = redirect_aligned;
      end
      S_HOLD: begin
        if (bus.redirect_valid) begin
          state_n = S_REQ;
          pc_n    = redirect_aligned;
        end else if (bus.instr_ready) begin
          state_n = S_REQ;
          pc_n    = pc + 32'(PC_STEP);
        end
      end
      default: state_n = S_REQ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_REQ;
      pc    <= RESET_PC;
      drop  <= 1'b0;
      run   <= 1'b0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      drop  <= drop_n;
      run   <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q    <= '0;
      pc_q       <= '0;
      misalign_q <= 1'b0;
    end else begin
      if (latch) begin
        instr_q <= bus.imem_rsp_data;
        pc_q    <= pc;
      end
      misalign_q <= bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00);
    end
  end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: imem responder model, scoreboard of expected
// fetches checked whenever decode consumes an instruction.
module tb_fetch_pc_unit;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fetch_pc_unit_if bus ();

  fetch_pc_unit #(
    .RESET_PC(32'h0000_0000),
    .PC_STEP (4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.master)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t        sb[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int unsigned cyc     = 0;
  int unsigned rsp_gap = 0;
  logic        dmode   = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return dmode ? 32'h0800_0010 : (a ^ 32'h1234_5600);
  endfunction

  function automatic void expect_fetch(input logic [31:0] a);
    sb.push_back({a, data_of(a)});
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_valid(input string tag);
    int unsigned n = 0;
    while (bus.instr_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk(tag, {31'd0, bus.instr_valid}, 32'd1);
  endtask

  task automatic wait_req(input string tag);
    int unsigned n = 0;
    while (bus.imem_req_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk(tag, {31'd0, bus.imem_req_valid}, 32'd1);
  endtask

  // imem: one response per accepted request, rsp_gap+1 cycles after acceptance
  initial begin
    int unsigned cnt = 0;
    logic [31:0] pend = '0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    forever begin
      @(negedge clk);
      bus.imem_rsp_valid = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          bus.imem_rsp_valid = 1'b1;
          bus.imem_rsp_data  = data_of(pend);
        end
      end
      #4;
      if (rst_n === 1'b1 && bus.imem_req_valid === 1'b1 && bus.imem_req_ready === 1'b1) begin
        pend = bus.imem_addr;
        cnt  = rsp_gap + 1;
      end
    end
  end

  // decode side: every consumed instruction must match the next scoreboard entry
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #4;
      if (rst_n === 1'b1 && bus.instr_valid === 1'b1 && bus.instr_ready === 1'b1 &&
          bus.redirect_valid !== 1'b1) begin
        n_tests++;
        assert (sb.size() != 0)
        else begin
          n_fail++;
          $error("FAIL sb_unexpected: observed pc_out %h with no entry expected", bus.pc_out);
        end
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("sb_pc_out", bus.pc_out, e.pc);
          chk("sb_instr_out", bus.instr_out, e.instr);
          chk("sb_pcadded", bus.pcadded, e.pc + 32'd4);
          chk("sb_fjump", {4'd0, bus.fjump}, {4'd0, e.instr[25:0], 2'b00});
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned t[3];
    rst_n              = 1'b0;
    bus.imem_req_ready = 1'b1;
    bus.instr_ready    = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    rsp_gap            = 3;
    dmode              = 1'b1;
    tick();
    tick();
    chk("rst_req_valid", {31'd0, bus.imem_req_valid}, 32'd0);
    chk("rst_instr_valid", {31'd0, bus.instr_valid}, 32'd0);
    chk("rst_instr_out", bus.instr_out, 32'd0);
    chk("rst_pc_out", bus.pc_out, 32'd0);
    chk("rst_misalign", {31'd0, bus.misalign_err}, 32'd0);
    chk("rst_pcadded", bus.pcadded, 32'd4);

    // reset asserted while a read is outstanding
    rst_n = 1'b1;
    chk("rel_req_low", {31'd0, bus.imem_req_valid}, 32'd0);
    tick();
    chk("rel_req_valid", {31'd0, bus.imem_req_valid}, 32'd1);
    chk("rel_addr", bus.imem_addr, 32'h0);
    tick();
    rst_n = 1'b0;
    tick();
    chk("midwait_req_valid", {31'd0, bus.imem_req_valid}, 32'd0);
    chk("midwait_instr_valid", {31'd0, bus.instr_valid}, 32'd0);
    repeat (4) tick();
    rsp_gap = 0;
    rst_n   = 1'b1;
    chk("rel2_req_low", {31'd0, bus.imem_req_valid}, 32'd0);

    // zero-wait streaming
    expect_fetch(32'h0);
    expect_fetch(32'h4);
    expect_fetch(32'h8);
    tick();
    chk("rel2_req_valid", {31'd0, bus.imem_req_valid}, 32'd1);
    chk("rel2_addr", bus.imem_addr, 32'h0);
    for (int k = 0; k < 3; k++) begin
      wait_valid("stream_valid");
      t[k] = cyc;
      if (k < 2) tick();
    end
    chk("stream_fjump", {4'd0, bus.fjump}, 32'h0000_0040);
    chk("stream_period1", t[1] - t[0], 32'd3);
    chk("stream_period2", t[2] - t[1], 32'd3);

    // imem back-pressure, then decode back-pressure
    bus.imem_req_ready = 1'b0;
    dmode              = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("stall_addr", bus.imem_addr, 32'hC);
      chk("stall_req_valid", {31'd0, bus.imem_req_valid}, 32'd1);
    end
    bus.instr_ready    = 1'b0;
    bus.imem_req_ready = 1'b1;
    expect_fetch(32'hC);
    wait_valid("hold_valid");
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("hold_instr_valid", {31'd0, bus.instr_valid}, 32'd1);
      chk("hold_pc_out", bus.pc_out, 32'hC);
      chk("hold_instr_out", bus.instr_out, data_of(32'hC));
    end
    bus.instr_ready = 1'b1;
    rsp_gap         = 2;

    // redirect while waiting on imem
    tick();
    wait_req("wait_req0");
    chk("wait_addr0", bus.imem_addr, 32'h10);
    tick();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0040_0100;
    tick();
    bus.redirect_valid = 1'b0;
    rsp_gap            = 0;
    chk("wait_misalign", {31'd0, bus.misalign_err}, 32'd0);
    chk("wait_instr_valid", {31'd0, bus.instr_valid}, 32'd0);
    wait_req("wait_req1");
    chk("wait_redir_addr", bus.imem_addr, 32'h0040_0100);
    expect_fetch(32'h0040_0100);

    // redirect in HOLD with decode ready: instruction killed
    wait_valid("hold_redir_v0");
    tick();
    wait_valid("hold_redir_v1");
    chk("hold_redir_pc_out", bus.pc_out, 32'h0040_0104);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_2000;
    tick();
    bus.redirect_valid = 1'b0;
    chk("kill_instr_valid", {31'd0, bus.instr_valid}, 32'd0);
    chk("kill_req_valid", {31'd0, bus.imem_req_valid}, 32'd1);
    chk("kill_addr", bus.imem_addr, 32'h2000);
    chk("kill_misalign", {31'd0, bus.misalign_err}, 32'd0);
    expect_fetch(32'h2000);

    // misaligned redirect in REQ, then PC wrap
    wait_valid("mis_v0");
    bus.imem_req_ready = 1'b0;
    tick();
    chk("mis_pre_addr", bus.imem_addr, 32'h2004);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hFFFF_FFFE;
    tick();
    bus.redirect_valid = 1'b0;
    chk("mis_pulse", {31'd0, bus.misalign_err}, 32'd1);
    chk("mis_addr", bus.imem_addr, 32'hFFFF_FFFC);
    chk("mis_req_valid", {31'd0, bus.imem_req_valid}, 32'd1);
    tick();
    chk("mis_pulse_end", {31'd0, bus.misalign_err}, 32'd0);
    chk("mis_addr_held", bus.imem_addr, 32'hFFFF_FFFC);
    expect_fetch(32'hFFFF_FFFC);
    expect_fetch(32'h0);
    bus.imem_req_ready = 1'b1;
    wait_valid("wrap_v0");
    tick();
    wait_valid("wrap_v1");
    bus.imem_req_ready = 1'b0;
    tick();
    tick();
    chk("sb_drained", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
